// File: rtl/opc6_io_pkg.sv
// Shared constants for the opc6 system bus responder: IO map, register bit
// positions, interrupt vectors and the bus access classification.
package opc6_io_pkg;

    // IO register offsets (address[2:0])
    localparam logic [2:0] IO_COUNT   = 3'd0;
    localparam logic [2:0] IO_RELOAD  = 3'd1;
    localparam logic [2:0] IO_CTRL    = 3'd2;
    localparam logic [2:0] IO_STATUS  = 3'd3;
    localparam logic [2:0] IO_SCRATCH = 3'd4;

    // CTRL bits
    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_IRQEN = 1;

    // STATUS bits
    localparam int unsigned STATUS_TIMER = 0;
    localparam int unsigned STATUS_EXT   = 1;

    // CPU interrupt vectors served by int_b[0] (timer) and int_b[1] (external)
    localparam logic [15:0] VEC_TIMER = 16'h0002;
    localparam logic [15:0] VEC_EXT   = 16'h0004;

    // Kind of bus cycle the CPU is presenting this clock
    typedef enum logic [1:0] {
        AccIdle,
        AccMem,
        AccIo
    } acc_e;

endpackage

// File: rtl/opc6_timer.sv
// 16-bit reloading down-counter with enable and interrupt-enable bits.
// Runs on every clock regardless of the CPU clock enable.
module opc6_timer
    import opc6_io_pkg::*;
(
    input  logic        clk,
    input  logic        reset_b,
    input  logic        wr_reload,
    input  logic        wr_ctrl,
    input  logic [15:0] wdata,
    output logic [15:0] count,
    output logic [15:0] reload,
    output logic        en,
    output logic        irqen,
    output logic        expire
);

    logic [15:0] count_q;
    logic [15:0] reload_q;
    logic        en_q;
    logic        irqen_q;
    logic        en_rise;

    // Expiry happens on the edge where a running counter sits at zero
    assign expire  = en_q && (count_q == 16'd0);
    assign en_rise = wr_ctrl && !en_q && wdata[CTRL_EN];

    // Control registers and the counter itself
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            count_q  <= 16'd0;
            reload_q <= 16'd0;
            en_q     <= 1'b0;
            irqen_q  <= 1'b0;
        end else begin
            if (wr_reload) begin
                reload_q <= wdata;
            end
            if (wr_ctrl) begin
                en_q    <= wdata[CTRL_EN];
                irqen_q <= wdata[CTRL_IRQEN];
            end
            // A fresh enable starts a full period; a running count keeps going
            if (en_rise) begin
                count_q <= reload_q;
            end else if (en_q) begin
                count_q <= expire ? reload_q : count_q - 16'd1;
            end
        end
    end

    assign count  = count_q;
    assign reload = reload_q;
    assign en     = en_q;
    assign irqen  = irqen_q;

endmodule

// File: rtl/opc6_sysbus.sv
// Responder end of the opc6 CPU bus: SRAM cycles with wait states via clken,
// a small IO block (timer, status, scratch) and the CPU interrupt lines.
module opc6_sysbus
    import opc6_io_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic [15:0] address,
    input  logic [15:0] dout,
    input  logic        rnw,
    input  logic        vpa,
    input  logic        vda,
    input  logic        vio,
    output logic [15:0] din,
    output logic        clken,
    output logic [1:0]  int_b,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    input  logic        ext_irq
);

    localparam logic [2:0] WaitLast = 3'(MEM_WAIT);

    acc_e        acc;
    logic [2:0]  wcnt_q;
    logic [2:0]  offset;
    logic        io_wr;
    logic [15:0] scratch_q;
    logic [1:0]  status_q;
    logic [1:0]  status_set;
    logic [1:0]  status_clr;
    logic [2:0]  sync_q;      // [1:0] synchronizer, [2] edge-detect history
    logic [15:0] t_count;
    logic [15:0] t_reload;
    logic        t_en;
    logic        t_irqen;
    logic        t_expire;
    logic [15:0] io_rdata;
    logic        unused_addr;

    assign offset      = address[2:0];
    assign unused_addr = ^address[15:3];

    // Classify the current bus cycle; memory strobes take precedence
    always_comb begin
        if (vpa | vda) begin
            acc = AccMem;
        end else if (vio) begin
            acc = AccIo;
        end else begin
            acc = AccIdle;
        end
    end

    // Hold the CPU until the SRAM data has had MEM_WAIT clocks to settle
    assign clken     = !reset_b || (acc != AccMem) || (wcnt_q == WaitLast);
    assign mem_addr  = address;
    assign mem_wdata = dout;
    assign mem_we    = reset_b && vda && !rnw && clken;
    assign io_wr     = reset_b && (acc == AccIo) && !rnw;

    // Wait-state counter restarts on every edge the CPU advances
    always_ff @(posedge clk) begin
        if (!reset_b || clken) begin
            wcnt_q <= 3'd0;
        end else begin
            wcnt_q <= wcnt_q + 3'd1;
        end
    end

    opc6_timer u_timer (
        .clk       (clk),
        .reset_b   (reset_b),
        .wr_reload (io_wr && (offset == IO_RELOAD)),
        .wr_ctrl   (io_wr && (offset == IO_CTRL)),
        .wdata     (dout),
        .count     (t_count),
        .reload    (t_reload),
        .en        (t_en),
        .irqen     (t_irqen),
        .expire    (t_expire)
    );

    // Interrupt sources and the W1C mask for STATUS
    always_comb begin
        status_set               = 2'b00;
        status_set[STATUS_TIMER] = t_expire;
        status_set[STATUS_EXT]   = sync_q[1] && !sync_q[2];
        status_clr = (io_wr && (offset == IO_STATUS)) ? dout[1:0] : 2'b00;
    end

    // STATUS, SCRATCH and the external interrupt synchronizer; set beats clear
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            status_q  <= 2'b00;
            scratch_q <= 16'h0000;
            sync_q    <= 3'b000;
        end else begin
            status_q <= (status_q & ~status_clr) | status_set;
            sync_q   <= {sync_q[1:0], ext_irq};
            if (io_wr && (offset == IO_SCRATCH)) begin
                scratch_q <= dout;
            end
        end
    end

    // IO read mux straight from the live register values
    always_comb begin
        io_rdata = 16'h0000;
        case (offset)
            IO_COUNT:   io_rdata = t_count;
            IO_RELOAD:  io_rdata = t_reload;
            IO_CTRL:    io_rdata = {14'd0, t_irqen, t_en};
            IO_STATUS:  io_rdata = {14'd0, status_q};
            IO_SCRATCH: io_rdata = scratch_q;
            default:    io_rdata = 16'h0000;
        endcase
    end

    // Return data only for read cycles; writes and idle cycles drive zero
    always_comb begin
        din = 16'h0000;
        if (reset_b && rnw) begin
            if (acc == AccMem) begin
                din = mem_rdata;
            end else if (acc == AccIo) begin
                din = io_rdata;
            end
        end
    end

    // Active-low interrupt lines, held until software clears STATUS
    always_comb begin
        int_b = 2'b11;
        if (reset_b) begin
            int_b[0] = !(status_q[STATUS_TIMER] && t_irqen);
            int_b[1] = !status_q[STATUS_EXT];
        end
    end

endmodule
